sdram_cmd_monitor: RTL and testbench

//   Passive decoder/checker on the SDR SDRAM pins driven by the SDRAM frame-buffer controller.

---
 rtl/sdram_cmd_monitor.sv | 226 ++++++++++++++++++++++
 tb/tb_sdram_cmd_monitor.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_monitor.sv
// sdram_cmd_monitor: passive SDR SDRAM command decoder and protocol checker.
// Decodes the pin command each clock, tracks the init sequence, per-bank
// open rows and ACT/PRE/AREF timings, and raises sticky error bits.
// Also counts reads, writes and refreshes.
module sdram_cmd_monitor #(
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int T_RFC     = 7,
    parameter int T_REF_MAX = 780,
    parameter int CNT_W     = 16
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iCKE,
    input  logic             iCS_N,
    input  logic             iRAS_N,
    input  logic             iCAS_N,
    input  logic             iWE_N,
    input  logic [1:0]       iBA,
    input  logic [12:0]      iSA,
    input  logic             iCLR,
    output logic [2:0]       oCMD,
    output logic             oCMD_VALID,
    output logic             oINIT_DONE,
    output logic [2:0]       oCAS_LAT,
    output logic [2:0]       oBURST_LEN,
    output logic [6:0]       oERR,
    output logic [CNT_W-1:0] oRD_CNT,
    output logic [CNT_W-1:0] oWR_CNT,
    output logic [CNT_W-1:0] oREF_CNT
);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_AREF = 3'd5;
    localparam logic [2:0] CMD_LMR  = 3'd6;
    localparam logic [2:0] CMD_BST  = 3'd7;

    // Timers hold "cycles since event" as seen at the next sample, and
    // saturate at the limit so an idle bank never looks like a violation.
    localparam int BT_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int BT_W   = $clog2(BT_MAX + 1);
    localparam int RF_W   = $clog2(T_RFC + 1);
    localparam int RI_W   = $clog2(T_REF_MAX + 3);

    localparam logic [BT_W-1:0] RCD_LIM  = BT_W'(T_RCD);
    localparam logic [BT_W-1:0] RP_LIM   = BT_W'(T_RP);
    localparam logic [RF_W-1:0] RFC_LIM  = RF_W'(T_RFC);
    // Refresh interval counter: value T_REF_MAX+1 means the interval has just
    // been exceeded; it then parks one higher so the error fires only once.
    localparam logic [RI_W-1:0] REF_LATE = RI_W'(T_REF_MAX + 1);
    localparam logic [RI_W-1:0] REF_SAT  = RI_W'(T_REF_MAX + 2);

    typedef enum logic [2:0] {
        ST_INIT_PRE  = 3'd0,
        ST_INIT_REF1 = 3'd1,
        ST_INIT_REF2 = 3'd2,
        ST_INIT_LMR  = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   run;

    logic [2:0] cmd;
    logic       is_act, is_rd, is_wr, is_rw, is_pre, is_aref, is_lmr;
    logic       ap;

    logic [3:0]             bank_open;
    logic [3:0][12:0]       bank_row;
    logic [3:0][BT_W-1:0]   act_age;
    logic [3:0][BT_W-1:0]   pre_age;
    logic [RF_W-1:0]        rfc_age;
    logic [RI_W-1:0]        ref_int;
    logic [6:0]             viol;

    // Open rows are tracked for visibility in simulation/debug only.
    logic unused_row;
    assign unused_row = ^bank_row;

    // Pin decode; a deselected or clock-gated cycle is a NOP.
    always_comb begin
        cmd = CMD_NOP;
        if (iCKE && !iCS_N) begin
            case ({iRAS_N, iCAS_N, iWE_N})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_AREF;
                3'b000:  cmd = CMD_LMR;
                3'b110:  cmd = CMD_BST;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    assign is_act  = (cmd == CMD_ACT);
    assign is_rd   = (cmd == CMD_RD);
    assign is_wr   = (cmd == CMD_WR);
    assign is_rw   = is_rd | is_wr;
    assign is_pre  = (cmd == CMD_PRE);
    assign is_aref = (cmd == CMD_AREF);
    assign is_lmr  = (cmd == CMD_LMR);
    assign ap      = iSA[10];

    // Init FSM state register.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= ST_INIT_PRE;
        else         state <= state_nxt;
    end

    // Init FSM next state: only the expected command advances.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT_PRE:  if (is_pre && ap) state_nxt = ST_INIT_REF1;
            ST_INIT_REF1: if (is_aref)      state_nxt = ST_INIT_REF2;
            ST_INIT_REF2: if (is_aref)      state_nxt = ST_INIT_LMR;
            ST_INIT_LMR:  if (is_lmr)       state_nxt = ST_RUN;
            default:                        state_nxt = ST_RUN;
        endcase
    end

    // Init FSM outputs.
    always_comb begin
        run = 1'b0;
        if (state == ST_RUN) run = 1'b1;
    end

    assign oINIT_DONE = run;

    // Violation detection for the command sampled this cycle.
    always_comb begin
        viol    = '0;
        viol[0] = (is_act && bank_open[iBA]) || (is_lmr && (|bank_open));
        viol[1] = is_rw && !bank_open[iBA];
        viol[2] = is_rw && (act_age[iBA] < RCD_LIM);
        viol[3] = is_act && (pre_age[iBA] < RP_LIM);
        viol[4] = (cmd != CMD_NOP) && (rfc_age < RFC_LIM);
        viol[5] = run && (ref_int == REF_LATE);
        viol[6] = (is_act || is_rw) && !run;
    end

    // Per-bank open/row state and ACT/PRE timers; violating commands still apply.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            bank_open <= '0;
            bank_row  <= '0;
            act_age   <= {4{RCD_LIM}};
            pre_age   <= {4{RP_LIM}};
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (is_act && iBA == 2'(b)) begin
                    bank_open[b] <= 1'b1;
                    bank_row[b]  <= iSA;
                    act_age[b]   <= BT_W'(1);
                end else if (act_age[b] < RCD_LIM) begin
                    act_age[b]   <= act_age[b] + 1'b1;
                end

                if ((is_pre && (ap || iBA == 2'(b))) || (is_rw && ap && iBA == 2'(b))) begin
                    bank_open[b] <= 1'b0;
                    pre_age[b]   <= BT_W'(1);
                end else if (pre_age[b] < RP_LIM) begin
                    pre_age[b]   <= pre_age[b] + 1'b1;
                end
            end
        end
    end

    // Refresh timers: short AREF recovery window and long refresh interval.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rfc_age <= RFC_LIM;
            ref_int <= REF_SAT;
        end else if (is_aref) begin
            rfc_age <= RF_W'(1);
            ref_int <= RI_W'(1);
        end else begin
            if (rfc_age < RFC_LIM) rfc_age <= rfc_age + 1'b1;
            if (ref_int < REF_SAT) ref_int <= ref_int + 1'b1;
        end
    end

    // Mode register capture once the LMR step of init has been reached.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oCAS_LAT   <= '0;
            oBURST_LEN <= '0;
        end else if (is_lmr && (state == ST_INIT_LMR || state == ST_RUN)) begin
            oCAS_LAT   <= iSA[6:4];
            oBURST_LEN <= iSA[2:0];
        end
    end

    // Registered command report, sticky errors and saturating counters.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oCMD       <= CMD_NOP;
            oCMD_VALID <= 1'b0;
            oERR       <= '0;
            oRD_CNT    <= '0;
            oWR_CNT    <= '0;
            oREF_CNT   <= '0;
        end else begin
            oCMD       <= cmd;
            oCMD_VALID <= (cmd != CMD_NOP);
            if (iCLR) begin
                oERR     <= '0;
                oRD_CNT  <= '0;
                oWR_CNT  <= '0;
                oREF_CNT <= '0;
            end else begin
                oERR <= oERR | viol;
                if (is_rd   && oRD_CNT  != '1) oRD_CNT  <= oRD_CNT  + 1'b1;
                if (is_wr   && oWR_CNT  != '1) oWR_CNT  <= oWR_CNT  + 1'b1;
                if (is_aref && oREF_CNT != '1) oREF_CNT <= oREF_CNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Bench for sdram_cmd_monitor: directed protocol scenarios plus random pin
// traffic, all checked every cycle against a timestamp-based reference model.
module tb_sdram_cmd_monitor;

    localparam int T_RCD     = 3;
    localparam int T_RP      = 3;
    localparam int T_RFC     = 7;
    localparam int T_REF_MAX = 780;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int NEVER     = -100000;

    localparam int NOP = 0, ACT = 1, RD = 2, WR = 3, PRE = 4, AREF = 5, LMR = 6, BST = 7;

    logic iCLK, iRST_n, iCKE, iCS_N, iRAS_N, iCAS_N, iWE_N, iCLR;
    logic [1:0]  iBA;
    logic [12:0] iSA;
    logic [2:0]  oCMD, oCAS_LAT, oBURST_LEN;
    logic        oCMD_VALID, oINIT_DONE;
    logic [6:0]  oERR;
    logic [CNT_W-1:0] oRD_CNT, oWR_CNT, oREF_CNT;

    sdram_cmd_monitor #(
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .T_REF_MAX(T_REF_MAX), .CNT_W(CNT_W)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iCKE(iCKE), .iCS_N(iCS_N),
        .iRAS_N(iRAS_N), .iCAS_N(iCAS_N), .iWE_N(iWE_N), .iBA(iBA), .iSA(iSA),
        .iCLR(iCLR), .oCMD(oCMD), .oCMD_VALID(oCMD_VALID), .oINIT_DONE(oINIT_DONE),
        .oCAS_LAT(oCAS_LAT), .oBURST_LEN(oBURST_LEN), .oERR(oERR),
        .oRD_CNT(oRD_CNT), .oWR_CNT(oWR_CNT), .oREF_CNT(oREF_CNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: event timestamps and plain counts.
    int       cyc;
    int       m_act[4];
    int       m_pre[4];
    bit       m_open[4];
    int       m_aref;
    int       m_stage;   // number of init steps completed, 4 = running
    logic [6:0] m_err;
    int       m_rd, m_wr, m_ref;
    int       m_cmd;
    logic [2:0] m_cas, m_bl;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_act[b] = NEVER; m_pre[b] = NEVER; m_open[b] = 0;
        end
        m_aref = NEVER; m_stage = 0; m_err = '0;
        m_rd = 0; m_wr = 0; m_ref = 0; m_cmd = NOP; m_cas = '0; m_bl = '0;
    endtask

    function automatic int decode(input logic cke, input logic cs_n, input logic [2:0] p);
        if (!cke || cs_n) return NOP;
        case (p)
            3'b011: return ACT;
            3'b101: return RD;
            3'b100: return WR;
            3'b010: return PRE;
            3'b001: return AREF;
            3'b000: return LMR;
            3'b110: return BST;
            default: return NOP;
        endcase
    endfunction

    function automatic logic [2:0] pins_of(input int c);
        case (c)
            ACT:  return 3'b011;
            RD:   return 3'b101;
            WR:   return 3'b100;
            PRE:  return 3'b010;
            AREF: return 3'b001;
            LMR:  return 3'b000;
            BST:  return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    // Apply the command the DUT just sampled to the model.
    task automatic model_step();
        logic [6:0] v;
        int  c, b;
        bit  a10, run, any_open;
        c   = decode(iCKE, iCS_N, {iRAS_N, iCAS_N, iWE_N});
        b   = int'(iBA);
        a10 = iSA[10];
        run = (m_stage == 4);
        any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
        v = '0;
        if (c == ACT) begin
            if (m_open[b])              v[0] = 1;
            if (cyc - m_pre[b] < T_RP)  v[3] = 1;
            if (!run)                   v[6] = 1;
        end
        if (c == RD || c == WR) begin
            if (!m_open[b])             v[1] = 1;
            if (cyc - m_act[b] < T_RCD) v[2] = 1;
            if (!run)                   v[6] = 1;
        end
        if (c == LMR && any_open)       v[0] = 1;
        if (c != NOP && cyc - m_aref < T_RFC) v[4] = 1;
        if (run && cyc - m_aref == T_REF_MAX + 1) v[5] = 1;

        if (iCLR) begin
            m_err = '0; m_rd = 0; m_wr = 0; m_ref = 0;
        end else begin
            m_err = m_err | v;
            if (c == RD   && m_rd  < CNT_MAX) m_rd++;
            if (c == WR   && m_wr  < CNT_MAX) m_wr++;
            if (c == AREF && m_ref < CNT_MAX) m_ref++;
        end

        if (c == LMR && m_stage >= 3) begin
            m_cas = iSA[6:4]; m_bl = iSA[2:0];
        end
        case (m_stage)
            0: if (c == PRE && a10) m_stage = 1;
            1: if (c == AREF)       m_stage = 2;
            2: if (c == AREF)       m_stage = 3;
            3: if (c == LMR)        m_stage = 4;
            default: ;
        endcase

        if (c == ACT) begin m_open[b] = 1; m_act[b] = cyc; end
        if (c == PRE) begin
            for (int k = 0; k < 4; k++)
                if (a10 || k == b) begin m_open[k] = 0; m_pre[k] = cyc; end
        end
        if ((c == RD || c == WR) && a10) begin m_open[b] = 0; m_pre[b] = cyc; end
        if (c == AREF) m_aref = cyc;
        m_cmd = c;
        cyc++;
    endtask

    task automatic check_all();
        chk("cmd",       32'(oCMD),       32'(m_cmd));
        chk("cmd_valid", 32'(oCMD_VALID), 32'(m_cmd != NOP));
        chk("err",       32'(oERR),       32'(m_err));
        chk("rd_cnt",    32'(oRD_CNT),    32'(m_rd));
        chk("wr_cnt",    32'(oWR_CNT),    32'(m_wr));
        chk("ref_cnt",   32'(oREF_CNT),   32'(m_ref));
        chk("init_done", 32'(oINIT_DONE), 32'(m_stage == 4));
        chk("cas_lat",   32'(oCAS_LAT),   32'(m_cas));
        chk("burst_len", 32'(oBURST_LEN), 32'(m_bl));
    endtask

    // One clock: drive on the falling edge, check 1 ns after the rising edge.
    task automatic drive(input logic cke, input logic cs_n, input logic [2:0] p,
                         input logic [1:0] ba, input logic [12:0] sa, input logic clr);
        @(negedge iCLK);
        iCKE = cke; iCS_N = cs_n; {iRAS_N, iCAS_N, iWE_N} = p;
        iBA = ba; iSA = sa; iCLR = clr;
        @(posedge iCLK);
        #1;
        model_step();
        check_all();
    endtask

    task automatic issue(input int c, input int b, input int sa);
        drive(1'b1, 1'b0, pins_of(c), 2'(b), 13'(sa), 1'b0);
    endtask

    task automatic clr_step();
        drive(1'b1, 1'b0, pins_of(NOP), 2'd0, 13'd0, 1'b1);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(NOP, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRST_n = 1'b0;
        iCKE = 1'b1; iCS_N = 1'b1; {iRAS_N, iCAS_N, iWE_N} = 3'b111;
        iBA = '0; iSA = '0; iCLR = 1'b0;
        #3;
        model_reset();
        check_all();
        @(negedge iCLK);
        iRST_n = 1'b1;
    endtask

    initial begin
        cyc = 0;
        iRST_n = 1'b1;
        iCKE = 1'b1; iCS_N = 1'b1; {iRAS_N, iCAS_N, iWE_N} = 3'b111;
        iBA = '0; iSA = '0; iCLR = 1'b0;
        model_reset();

        // Reset state.
        do_reset();

        // Init sequence.
        issue(PRE, 0, 13'h400);
        nops(2);
        issue(AREF, 0, 0);
        nops(6);
        issue(AREF, 0, 0);
        nops(6);
        issue(LMR, 0, 13'h023);
        chk("init_done_after_lmr", 32'(oINIT_DONE), 32'd1);
        chk("cas_lat_after_lmr",   32'(oCAS_LAT),   32'd2);
        chk("burst_after_lmr",     32'(oBURST_LEN), 32'd3);
        chk("err_after_init",      32'(oERR),       32'd0);
        nops(8);

        // tRCD: RD at +2 flags, RD at +3 is legal.
        issue(ACT, 1, 13'h0123);
        nops(1);
        issue(RD, 1, 0);
        chk("trcd_short", 32'(oERR), 32'h04);
        issue(RD, 1, 0);
        chk("trcd_exact_err", 32'(oERR),    32'h04);
        chk("trcd_exact_rd",  32'(oRD_CNT), 32'd2);

        // Double ACT and tRP.
        issue(ACT, 0, 13'h0044);
        issue(ACT, 0, 13'h0055);
        chk("act_open_bank", 32'(oERR), 32'h05);
        issue(PRE, 0, 0);
        nops(1);
        issue(ACT, 0, 13'h0066);
        chk("trp_short", 32'(oERR), 32'h0D);
        clr_step();
        chk("clr_errs", 32'(oERR), 32'h00);

        // Closed-bank access and auto-precharge.
        issue(RD, 2, 0);
        chk("rd_closed_bank", 32'(oERR), 32'h02);
        clr_step();
        issue(WR, 0, 13'h0400);
        issue(RD, 0, 0);
        chk("rd_after_autopre", 32'(oERR),    32'h02);
        chk("wr_count_one",     32'(oWR_CNT), 32'd1);

        // Read counter saturation.
        clr_step();
        for (int i = 0; i < 18; i++) issue(RD, 1, 0);
        chk("rd_cnt_saturate", 32'(oRD_CNT), 32'(CNT_MAX));

        // Refresh interval: 780 cycles legal, 781 flags, and only once.
        clr_step();
        issue(AREF, 0, 0);
        nops(T_REF_MAX);
        chk("ref_interval_limit", 32'(oERR[5]), 32'd0);
        nops(1);
        chk("ref_interval_late", 32'(oERR[5]), 32'd1);
        clr_step();
        nops(20);
        chk("ref_late_once", 32'(oERR), 32'd0);

        // tRFC: ACT at +6 after AREF.
        issue(AREF, 0, 0);
        nops(5);
        issue(ACT, 0, 13'h0011);
        chk("trfc_short", 32'(oERR), 32'h10);

        // Random traffic, with one reset mid-stream.
        for (int i = 0; i < 1500; i++) begin
            logic cke, cs_n, clr;
            logic [2:0] p;
            if (i == 700) do_reset();
            cke  = ($urandom_range(0, 19) != 0);
            cs_n = ($urandom_range(0, 19) == 0);
            clr  = ($urandom_range(0, 299) == 0);
            p    = ($urandom_range(0, 99) < 45) ? 3'b111 : 3'($urandom);
            drive(cke, cs_n, p, 2'($urandom), 13'($urandom), clr);
        end

        // Pre-init ACT and CKE gating.
        do_reset();
        chk("reset_init_done", 32'(oINIT_DONE), 32'd0);
        issue(ACT, 0, 0);
        chk("act_before_init", 32'(oERR), 32'h40);
        drive(1'b0, 1'b0, pins_of(ACT), 2'd1, 13'd0, 1'b0);
        chk("cke_low_valid", 32'(oCMD_VALID), 32'd0);
        chk("cke_low_err",   32'(oERR),       32'h40);
        clr_step();
        drive(1'b0, 1'b0, pins_of(ACT), 2'd2, 13'd0, 1'b0);
        chk("cke_low_no_err", 32'(oERR), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
